prefix_sub_16b_pipe: RTL

PREFIX_SUB_16B_PIPE -- requirements
Module: prefix_sub_16b_pipe

---
 rtl/prefix_sub_16b_pipe.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/prefix_sub_16b_pipe.sv
// prefix_sub_16b_pipe: 16-bit subtractor (a - b) with a Kogge-Stone carry tree split over a 2-stage valid/ready pipeline.
// Optional macro SUB_SATURATE_EN clamps signed-overflow results to 16'h7FFF / 16'h8000.
module prefix_sub_16b_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        bout,
  output logic        ovf
);

  logic        s1_valid_r;
  logic        s2_valid_r;
  logic        s1_load_s;
  logic        s2_load_s;

  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [15:0] gc_s;
  logic [15:0] g1_s;
  logic [15:0] g2_s;
  logic [15:0] g3_s;
  logic [15:0] g4_s;
  logic [15:2] p1_s;
  logic [15:4] p2_s;
  logic [15:8] p3_s;

  logic [15:0] s1_p_r;
  logic [15:0] s1_g3_r;
  logic [15:8] s1_p3_r;
  logic        s1_a15_r;
  logic        s1_b15_r;

  logic [15:0] sum_s;
  logic [15:0] diff_next_s;
  logic        bout_s;
  logic        ovf_s;

  assign s2_load_s = s1_valid_r & (~s2_valid_r | out_ready);
  assign in_ready  = ~s1_valid_r | s2_load_s;
  assign s1_load_s = in_valid & in_ready;
  assign out_valid = s2_valid_r;

  assign g_s = a & ~b;
  assign p_s = a ^ ~b;
  // The +1 carry-in is folded into bit 0, so any group term that reaches bit 0 is the true carry-out.
  assign gc_s = {g_s[15:1], g_s[0] | p_s[0]};

  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_tree
      if (i < 1) begin : g_l1_pass
        assign g1_s[i] = gc_s[i];
      end else begin : g_l1_cell
        assign g1_s[i] = gc_s[i] | (p_s[i] & gc_s[i-1]);
      end
      if (i >= 2) begin : g_l1_p
        assign p1_s[i] = p_s[i] & p_s[i-1];
      end

      if (i < 2) begin : g_l2_pass
        assign g2_s[i] = g1_s[i];
      end else begin : g_l2_cell
        assign g2_s[i] = g1_s[i] | (p1_s[i] & g1_s[i-2]);
      end
      if (i >= 4) begin : g_l2_p
        assign p2_s[i] = p1_s[i] & p1_s[i-2];
      end

      if (i < 4) begin : g_l3_pass
        assign g3_s[i] = g2_s[i];
      end else begin : g_l3_cell
        assign g3_s[i] = g2_s[i] | (p2_s[i] & g2_s[i-4]);
      end
      if (i >= 8) begin : g_l3_p
        assign p3_s[i] = p2_s[i] & p2_s[i-4];
      end

      // Last prefix level works on the stage-1 registers.
      if (i < 8) begin : g_l4_pass
        assign g4_s[i] = s1_g3_r[i];
      end else begin : g_l4_cell
        assign g4_s[i] = s1_g3_r[i] | (s1_p3_r[i] & s1_g3_r[i-8]);
      end
    end
  endgenerate

  assign sum_s  = s1_p_r ^ {g4_s[14:0], 1'b1};
  assign bout_s = ~g4_s[15];
  assign ovf_s  = (s1_a15_r ^ s1_b15_r) & (sum_s[15] ^ s1_a15_r);

  // Result selection: wrap-around, or signed clamp when saturation is built in.
  always_comb begin
    diff_next_s = sum_s;
`ifdef SUB_SATURATE_EN
    if (ovf_s) begin
      diff_next_s = s1_a15_r ? 16'h8000 : 16'h7FFF;
    end else begin
      diff_next_s = sum_s;
    end
`endif
  end

  // Stage 1: bit-level propagate, prefix levels 1-3 and operand sign bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_p_r     <= 16'h0000;
      s1_g3_r    <= 16'h0000;
      s1_p3_r    <= 8'h00;
      s1_a15_r   <= 1'b0;
      s1_b15_r   <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      s1_p_r     <= p_s;
      s1_g3_r    <= g3_s;
      s1_p3_r    <= p3_s;
      s1_a15_r   <= a[15];
      s1_b15_r   <= b[15];
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: final result registers; data holds whenever nothing new loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      diff       <= 16'h0000;
      bout       <= 1'b0;
      ovf        <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= 1'b1;
      diff       <= diff_next_s;
      bout       <= bout_s;
      ovf        <= ovf_s;
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

endmodule
